// File: rtl/hazard3_break_seq_pkg.sv
// Shared hazard3 debug definitions: sequencer state encodings, dcsr cause
// codes, cause-selection payload and the debug/trap CSR addresses.
package hazard3_break_seq_pkg;

  localparam int unsigned W_STATE = 3;
  localparam int unsigned W_CAUSE = 3;
  localparam int unsigned W_CSR   = 12;

  // Break sequencer states
  typedef enum logic [W_STATE-1:0] {
    ST_IDLE   = 3'd0,
    ST_M_REQ  = 3'd1,
    ST_D_REQ  = 3'd2,
    ST_HALTED = 3'd3,
    ST_RESUME = 3'd4
  } break_state_e;

  // dcsr.cause encodings
  localparam logic [W_CAUSE-1:0] CAUSE_NONE    = 3'd0;
  localparam logic [W_CAUSE-1:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [W_CAUSE-1:0] CAUSE_TRIGGER = 3'd2;
  localparam logic [W_CAUSE-1:0] CAUSE_HALTREQ = 3'd3;
  localparam logic [W_CAUSE-1:0] CAUSE_STEP    = 3'd4;

  // CSR addresses touched by the debug/trap path
  localparam logic [W_CSR-1:0] CSR_MEPC    = 12'h341;
  localparam logic [W_CSR-1:0] CSR_TSELECT = 12'h7a0;
  localparam logic [W_CSR-1:0] CSR_TDATA1  = 12'h7a1;
  localparam logic [W_CSR-1:0] CSR_TDATA2  = 12'h7a2;
  localparam logic [W_CSR-1:0] CSR_DCSR    = 12'h7b0;
  localparam logic [W_CSR-1:0] CSR_DPC     = 12'h7b1;

  // Result of the cause priority encoder
  typedef struct packed {
    logic               valid;   // some cause selected
    logic               to_m;    // M-mode breakpoint trap rather than debug entry
    logic [W_CAUSE-1:0] cause;   // dcsr.cause for debug entry
  } break_sel_t;

endpackage

// File: rtl/hazard3_break_seq.sv
// Breakpoint / debug-entry sequencer: picks the highest-priority break cause
// at the X boundary, kills the instruction, and runs the M-trap or debug-entry
// handshake through halt and resume, including single-step re-entry.
module hazard3_break_seq
  import hazard3_break_seq_pkg::*;
#(
  parameter int unsigned W_ADDR = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              x_valid,
  input  logic              x_stall,
  input  logic [W_ADDR-1:0] x_pc,
  input  logic              x_retire,
  input  logic              break_any,
  input  logic              break_d_mode,
  input  logic              x_ebreak,
  input  logic              ebreakm,
  input  logic              dbg_halt_req,
  input  logic              dbg_resume_req,
  input  logic              dbg_step,
  output logic              m_trap_req,
  input  logic              m_trap_ack,
  output logic              d_entry_req,
  input  logic              d_entry_ack,
  output logic [2:0]        d_cause,
  output logic [W_ADDR-1:0] d_pc,
  output logic              x_kill,
  output logic              d_mode,
  output logic              resumed
);

  // Cause priority: trigger-D, trigger-M, ebreak, haltreq, step.
  // Trigger matches are masked while the post-resume skip is pending.
  function automatic break_sel_t sel_cause(
    input logic trig_en,
    input logic brk_any,
    input logic brk_d,
    input logic ebrk,
    input logic ebrk_m,
    input logic haltreq,
    input logic armed
  );
    break_sel_t s;
    s = '0;
    if (trig_en && brk_any && brk_d) begin
      s.valid = 1'b1;
      s.cause = CAUSE_TRIGGER;
    end else if (trig_en && brk_any) begin
      s.valid = 1'b1;
      s.to_m  = 1'b1;
    end else if (ebrk && ebrk_m) begin
      s.valid = 1'b1;
      s.cause = CAUSE_EBREAK;
    end else if (haltreq) begin
      s.valid = 1'b1;
      s.cause = CAUSE_HALTREQ;
    end else if (armed) begin
      s.valid = 1'b1;
      s.cause = CAUSE_STEP;
    end
    return s;
  endfunction

  break_state_e       state_q, state_d;
  logic               m_trap_req_q, m_trap_req_d;
  logic               d_entry_req_q, d_entry_req_d;
  logic [2:0]         d_cause_q, d_cause_d;
  logic [W_ADDR-1:0]  d_pc_q, d_pc_d;
  logic               d_mode_q, d_mode_d;
  logic               resumed_q, resumed_d;
  logic               skip_once_q, skip_once_d;
  logic               step_pending_q, step_pending_d;
  logic               step_armed_q, step_armed_d;

  logic               x_fire;
  logic               in_idle;
  break_sel_t         sel;
  logic               take_break;

  // Cause selection for the instruction currently at X
  always_comb begin
    x_fire     = x_valid && !x_stall;
    in_idle    = (state_q == ST_IDLE);
    sel        = sel_cause(!skip_once_q, break_any, break_d_mode, x_ebreak,
                           ebreakm, dbg_halt_req, step_armed_q);
    take_break = in_idle && x_fire && sel.valid;
  end

  // State register and registered outputs/flags, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      m_trap_req_q   <= 1'b0;
      d_entry_req_q  <= 1'b0;
      d_cause_q      <= CAUSE_NONE;
      d_pc_q         <= '0;
      d_mode_q       <= 1'b0;
      resumed_q      <= 1'b0;
      skip_once_q    <= 1'b0;
      step_pending_q <= 1'b0;
      step_armed_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      m_trap_req_q   <= m_trap_req_d;
      d_entry_req_q  <= d_entry_req_d;
      d_cause_q      <= d_cause_d;
      d_pc_q         <= d_pc_d;
      d_mode_q       <= d_mode_d;
      resumed_q      <= resumed_d;
      skip_once_q    <= skip_once_d;
      step_pending_q <= step_pending_d;
      step_armed_q   <= step_armed_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (take_break) state_d = sel.to_m ? ST_M_REQ : ST_D_REQ;
      ST_M_REQ:  if (m_trap_ack) state_d = ST_IDLE;
      ST_D_REQ:  if (d_entry_ack) state_d = ST_HALTED;
      ST_HALTED: if (dbg_resume_req) state_d = ST_RESUME;
      ST_RESUME: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: combinational kill plus next values of registered outputs
  always_comb begin
    x_kill         = take_break;
    m_trap_req_d   = (state_d == ST_M_REQ);
    d_entry_req_d  = (state_d == ST_D_REQ);
    d_mode_d       = (state_d == ST_HALTED) || (state_d == ST_RESUME);
    resumed_d      = (state_d == ST_RESUME);
    d_pc_d         = d_pc_q;
    d_cause_d      = d_cause_q;
    skip_once_d    = skip_once_q;
    step_pending_d = step_pending_q;
    step_armed_d   = step_armed_q;

    // Capture dpc/mepc and, for debug entry, the dcsr cause
    if (take_break) begin
      d_pc_d = x_pc;
      if (!sel.to_m) d_cause_d = sel.cause;
    end

    // Resume arms the trigger skip and optionally a pending single step
    if (state_q == ST_RESUME) begin
      skip_once_d    = 1'b1;
      step_pending_d = dbg_step;
    end else if (in_idle && x_retire) begin
      skip_once_d = 1'b0;
      if (step_pending_q) begin
        step_pending_d = 1'b0;
        step_armed_d   = 1'b1;
      end
    end

    // Any break entry consumes the step
    if ((state_d == ST_M_REQ) || (state_d == ST_D_REQ)) step_armed_d = 1'b0;
  end

  assign m_trap_req  = m_trap_req_q;
  assign d_entry_req = d_entry_req_q;
  assign d_cause     = d_cause_q;
  assign d_pc        = d_pc_q;
  assign d_mode      = d_mode_q;
  assign resumed     = resumed_q;

endmodule

// File: tb/tb_hazard3_break_seq.sv
// Directed bench for hazard3_break_seq.
module tb_hazard3_break_seq;

  localparam int unsigned W_ADDR = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              x_valid, x_stall, x_retire;
  logic [W_ADDR-1:0] x_pc;
  logic              break_any, break_d_mode, x_ebreak, ebreakm;
  logic              dbg_halt_req, dbg_resume_req, dbg_step;
  logic              m_trap_req, m_trap_ack, d_entry_req, d_entry_ack;
  logic [2:0]        d_cause;
  logic [W_ADDR-1:0] d_pc;
  logic              x_kill, d_mode, resumed;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard3_break_seq #(.W_ADDR(W_ADDR)) dut (
    .clk(clk), .rst(rst),
    .x_valid(x_valid), .x_stall(x_stall), .x_pc(x_pc), .x_retire(x_retire),
    .break_any(break_any), .break_d_mode(break_d_mode),
    .x_ebreak(x_ebreak), .ebreakm(ebreakm),
    .dbg_halt_req(dbg_halt_req), .dbg_resume_req(dbg_resume_req), .dbg_step(dbg_step),
    .m_trap_req(m_trap_req), .m_trap_ack(m_trap_ack),
    .d_entry_req(d_entry_req), .d_entry_ack(d_entry_ack),
    .d_cause(d_cause), .d_pc(d_pc),
    .x_kill(x_kill), .d_mode(d_mode), .resumed(resumed)
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    x_valid = 0; x_stall = 0; x_retire = 0; x_pc = '0;
    break_any = 0; break_d_mode = 0; x_ebreak = 0; ebreakm = 0;
    dbg_halt_req = 0; dbg_resume_req = 0; dbg_step = 0;
    m_trap_ack = 0; d_entry_ack = 0;
  endtask

  // HALTED -> RESUME -> IDLE, then retire one plain instruction to drop the skip
  task automatic resume_to_idle();
    dbg_resume_req = 1;
    tick();
    dbg_resume_req = 0;
    tick();
    x_valid = 1; x_retire = 1; x_pc = 32'h0000_0f00;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    break_any = 1; x_valid = 1;
    tick(); tick();
    rst = 0;
    clear_inputs();
    #1;
    n_checks++; if (m_trap_req !== 1'b0) begin n_fail++; $display("FAIL reset_m_trap_req: got %b want 0", m_trap_req); end
    n_checks++; if (d_entry_req !== 1'b0) begin n_fail++; $display("FAIL reset_d_entry_req: got %b want 0", d_entry_req); end
    n_checks++; if (d_cause !== 3'd0) begin n_fail++; $display("FAIL reset_d_cause: got %0d want 0", d_cause); end
    n_checks++; if (d_pc !== 32'h0) begin n_fail++; $display("FAIL reset_d_pc: got %h want 0", d_pc); end
    n_checks++; if (d_mode !== 1'b0) begin n_fail++; $display("FAIL reset_d_mode: got %b want 0", d_mode); end
    n_checks++; if (resumed !== 1'b0) begin n_fail++; $display("FAIL reset_resumed: got %b want 0", resumed); end
    n_checks++; if (x_kill !== 1'b0) begin n_fail++; $display("FAIL reset_x_kill: got %b want 0", x_kill); end
  endtask

  task automatic test_trigger_d();
    x_valid = 1; break_any = 1; break_d_mode = 1; x_pc = 32'h0000_1000;
    #1;
    n_checks++; if (x_kill !== 1'b1) begin n_fail++; $display("FAIL trigd_kill: got %b want 1", x_kill); end
    n_checks++; if (d_entry_req !== 1'b0) begin n_fail++; $display("FAIL trigd_req_early: got %b want 0", d_entry_req); end
    tick();
    // Inputs outside IDLE are ignored: still firing with a trigger
    x_pc = 32'h0000_1234;
    #1;
    n_checks++; if (x_kill !== 1'b0) begin n_fail++; $display("FAIL trigd_kill_in_dreq: got %b want 0", x_kill); end
    n_checks++; if (d_entry_req !== 1'b1) begin n_fail++; $display("FAIL trigd_req: got %b want 1", d_entry_req); end
    n_checks++; if (d_cause !== 3'd2) begin n_fail++; $display("FAIL trigd_cause: got %0d want 2", d_cause); end
    n_checks++; if (d_pc !== 32'h0000_1000) begin n_fail++; $display("FAIL trigd_pc: got %h want 00001000", d_pc); end
    tick();
    n_checks++; if (d_entry_req !== 1'b1) begin n_fail++; $display("FAIL trigd_req_hold: got %b want 1", d_entry_req); end
    n_checks++; if (d_pc !== 32'h0000_1000) begin n_fail++; $display("FAIL trigd_pc_hold: got %h want 00001000", d_pc); end
    d_entry_ack = 1;
    tick();
    d_entry_ack = 0;
    n_checks++; if (d_mode !== 1'b1) begin n_fail++; $display("FAIL trigd_dmode: got %b want 1", d_mode); end
    n_checks++; if (d_entry_req !== 1'b0) begin n_fail++; $display("FAIL trigd_req_drop: got %b want 0", d_entry_req); end
  endtask

  task automatic test_resume_skip();
    // Trigger keeps matching through the resume
    dbg_resume_req = 1;
    tick();
    dbg_resume_req = 0;
    x_valid = 1; break_any = 1; break_d_mode = 1; x_pc = 32'h0000_1000;
    #1;
    n_checks++; if (resumed !== 1'b1) begin n_fail++; $display("FAIL resume_pulse: got %b want 1", resumed); end
    n_checks++; if (d_mode !== 1'b1) begin n_fail++; $display("FAIL resume_dmode: got %b want 1", d_mode); end
    n_checks++; if (x_kill !== 1'b0) begin n_fail++; $display("FAIL resume_kill: got %b want 0", x_kill); end
    tick();
    x_retire = 1;
    #1;
    n_checks++; if (resumed !== 1'b0) begin n_fail++; $display("FAIL resume_pulse_end: got %b want 0", resumed); end
    n_checks++; if (d_mode !== 1'b0) begin n_fail++; $display("FAIL resume_dmode_clr: got %b want 0", d_mode); end
    n_checks++; if (x_kill !== 1'b0) begin n_fail++; $display("FAIL skip_first_kill: got %b want 0", x_kill); end
    tick();
    x_retire = 0; x_pc = 32'h0000_1004;
    #1;
    n_checks++; if (x_kill !== 1'b1) begin n_fail++; $display("FAIL skip_second_kill: got %b want 1", x_kill); end
    tick();
    clear_inputs();
    #1;
    n_checks++; if (d_entry_req !== 1'b1) begin n_fail++; $display("FAIL skip_second_req: got %b want 1", d_entry_req); end
    n_checks++; if (d_cause !== 3'd2) begin n_fail++; $display("FAIL skip_second_cause: got %0d want 2", d_cause); end
    n_checks++; if (d_pc !== 32'h0000_1004) begin n_fail++; $display("FAIL skip_second_pc: got %h want 00001004", d_pc); end
    d_entry_ack = 1;
    tick();
    d_entry_ack = 0;
  endtask

  task automatic test_step();
    dbg_resume_req = 1; dbg_step = 1;
    tick();
    dbg_resume_req = 0;
    tick();
    x_valid = 1; x_retire = 1; x_pc = 32'h0000_2000;
    #1;
    n_checks++; if (x_kill !== 1'b0) begin n_fail++; $display("FAIL step_first_kill: got %b want 0", x_kill); end
    tick();
    x_retire = 0; x_pc = 32'h0000_2004;
    #1;
    n_checks++; if (x_kill !== 1'b1) begin n_fail++; $display("FAIL step_second_kill: got %b want 1", x_kill); end
    tick();
    clear_inputs();
    #1;
    n_checks++; if (d_entry_req !== 1'b1) begin n_fail++; $display("FAIL step_req: got %b want 1", d_entry_req); end
    n_checks++; if (d_cause !== 3'd4) begin n_fail++; $display("FAIL step_cause: got %0d want 4", d_cause); end
    n_checks++; if (d_pc !== 32'h0000_2004) begin n_fail++; $display("FAIL step_pc: got %h want 00002004", d_pc); end
    d_entry_ack = 1;
    tick();
    d_entry_ack = 0;
    resume_to_idle();
    // Step consumed: a plain fire is no longer killed
    x_valid = 1; x_pc = 32'h0000_2100;
    #1;
    n_checks++; if (x_kill !== 1'b0) begin n_fail++; $display("FAIL step_disarmed_kill: got %b want 0", x_kill); end
    tick();
    clear_inputs();
  endtask

  task automatic test_trigger_m();
    x_valid = 1; break_any = 1; break_d_mode = 0; x_pc = 32'h0000_3000;
    #1;
    n_checks++; if (x_kill !== 1'b1) begin n_fail++; $display("FAIL trigm_kill: got %b want 1", x_kill); end
    tick();
    clear_inputs();
    dbg_halt_req = 1; x_valid = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (m_trap_req !== 1'b1) begin n_fail++; $display("FAIL trigm_req_hold%0d: got %b want 1", i, m_trap_req); end
      n_checks++; if (d_mode !== 1'b0 || d_entry_req !== 1'b0) begin n_fail++; $display("FAIL trigm_no_debug%0d: got %b%b want 00", i, d_mode, d_entry_req); end
      tick();
    end
    n_checks++; if (d_pc !== 32'h0000_3000) begin n_fail++; $display("FAIL trigm_pc: got %h want 00003000", d_pc); end
    x_valid = 0;
    m_trap_ack = 1;
    tick();
    m_trap_ack = 0;
    n_checks++; if (m_trap_req !== 1'b0) begin n_fail++; $display("FAIL trigm_req_drop: got %b want 0", m_trap_req); end
    n_checks++; if (d_mode !== 1'b0) begin n_fail++; $display("FAIL trigm_dmode: got %b want 0", d_mode); end
    // Haltreq held off during M_REQ, taken at the next IDLE fire
    tick();
    n_checks++; if (d_entry_req !== 1'b0) begin n_fail++; $display("FAIL halt_no_latch: got %b want 0", d_entry_req); end
    x_valid = 1; x_pc = 32'h0000_3010;
    #1;
    n_checks++; if (x_kill !== 1'b1) begin n_fail++; $display("FAIL halt_reeval_kill: got %b want 1", x_kill); end
    tick();
    clear_inputs();
    n_checks++; if (d_cause !== 3'd3) begin n_fail++; $display("FAIL halt_reeval_cause: got %0d want 3", d_cause); end
    d_entry_ack = 1;
    tick();
    d_entry_ack = 0;
    resume_to_idle();
  endtask

  task automatic test_priority();
    // Stalled X does not fire
    x_valid = 1; x_stall = 1; break_any = 1; break_d_mode = 1; x_pc = 32'h0000_4000;
    #1;
    n_checks++; if (x_kill !== 1'b0) begin n_fail++; $display("FAIL stall_kill: got %b want 0", x_kill); end
    // Trigger beats ebreak and haltreq; ack in the same cycle as req
    x_stall = 0; x_ebreak = 1; ebreakm = 1; dbg_halt_req = 1;
    #1;
    n_checks++; if (x_kill !== 1'b1) begin n_fail++; $display("FAIL prio_all_kill: got %b want 1", x_kill); end
    tick();
    clear_inputs();
    d_entry_ack = 1;
    #1;
    n_checks++; if (d_cause !== 3'd2) begin n_fail++; $display("FAIL prio_all_cause: got %0d want 2", d_cause); end
    tick();
    d_entry_ack = 0;
    n_checks++; if (d_mode !== 1'b1) begin n_fail++; $display("FAIL prio_same_ack: got %b want 1", d_mode); end
    resume_to_idle();
    // Ebreak beats haltreq
    x_valid = 1; x_ebreak = 1; ebreakm = 1; dbg_halt_req = 1; x_pc = 32'h0000_4010;
    tick();
    clear_inputs();
    n_checks++; if (d_cause !== 3'd1) begin n_fail++; $display("FAIL prio_ebreak_cause: got %0d want 1", d_cause); end
    d_entry_ack = 1;
    tick();
    d_entry_ack = 0;
    resume_to_idle();
    // Ebreak without ebreakm falls through to haltreq
    x_valid = 1; x_ebreak = 1; ebreakm = 0; dbg_halt_req = 1; x_pc = 32'h0000_4020;
    tick();
    clear_inputs();
    n_checks++; if (d_cause !== 3'd3) begin n_fail++; $display("FAIL prio_halt_cause: got %0d want 3", d_cause); end
    n_checks++; if (d_pc !== 32'h0000_4020) begin n_fail++; $display("FAIL prio_halt_pc: got %h want 00004020", d_pc); end
    d_entry_ack = 1;
    tick();
    d_entry_ack = 0;
    resume_to_idle();
  endtask

  task automatic test_reset_mid();
    x_valid = 1; dbg_halt_req = 1; x_pc = 32'h0000_5000;
    tick();
    clear_inputs();
    n_checks++; if (d_entry_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req: got %b want 1", d_entry_req); end
    rst = 1;
    tick();
    rst = 0;
    n_checks++; if (d_entry_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_drop: got %b want 0", d_entry_req); end
    n_checks++; if (d_mode !== 1'b0) begin n_fail++; $display("FAIL rstmid_dmode: got %b want 0", d_mode); end
    n_checks++; if (d_pc !== 32'h0) begin n_fail++; $display("FAIL rstmid_pc: got %h want 0", d_pc); end
    // Back in IDLE: a fresh haltreq fire is taken
    x_valid = 1; dbg_halt_req = 1; x_pc = 32'h0000_5004;
    #1;
    n_checks++; if (x_kill !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle_kill: got %b want 1", x_kill); end
    tick();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_trigger_d();
    test_resume_skip();
    test_step();
    test_trigger_m();
    test_priority();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard3_break_seq.md
HAZARD3_BREAK_SEQ -- requirements
Module: hazard3_break_seq

Interface
REQ-001 SHALL have parameter W_ADDR, default 32, meaning PC/dpc width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have ports x_valid (input, 1, instruction at stage-X boundary) and x_stall (input, 1, X stalled); X "fires" when x_valid && !x_stall.
REQ-005 SHALL have ports x_pc (input, W_ADDR, PC of X instruction) and x_retire (input, 1, X instruction retired this cycle).
REQ-006 SHALL have ports break_any and break_d_mode (input, 1 each), the trigger-unit break request.
REQ-007 SHALL have ports x_ebreak (input, 1, X is EBREAK) and ebreakm (input, 1, dcsr.ebreakm).
REQ-008 SHALL have ports dbg_halt_req, dbg_resume_req and dbg_step (input, 1 each), from the DM and dcsr.step.
REQ-009 SHALL have ports m_trap_req (output, 1) and m_trap_ack (input, 1), the M-mode breakpoint trap handshake.
REQ-010 SHALL have ports d_entry_req (output, 1) and d_entry_ack (input, 1), the debug-entry handshake.
REQ-011 SHALL have ports d_cause (output, 3, dcsr.cause) and d_pc (output, W_ADDR, dpc/mepc value).
REQ-012 SHALL have ports x_kill (output, 1, suppress X commit), d_mode (output, 1, core halted) and resumed (output, 1, resume-ack pulse).

Function
REQ-013 SHALL implement states IDLE, M_REQ, D_REQ, HALTED and RESUME.
REQ-014 In IDLE, when X fires, the block SHALL select one cause, highest first: trigger-D (break_any && break_d_mode), trigger-M (break_any && !break_d_mode), ebreak (x_ebreak && ebreakm), haltreq (dbg_halt_req), step (step_armed).
REQ-015 On selection, x_kill SHALL assert combinationally in the same cycle, d_pc SHALL latch x_pc, and d_cause SHALL latch 2/1/3/4 for trigger-D/ebreak/haltreq/step.
REQ-016 Trigger-M SHALL transition to M_REQ; every other cause SHALL transition to D_REQ at the next edge.
REQ-017 m_trap_req and d_entry_req SHALL be registered, held high in M_REQ and D_REQ respectively, and held stable until acknowledged.
REQ-018 From M_REQ, m_trap_ack SHALL transition to IDLE; from D_REQ, d_entry_ack SHALL transition to HALTED; ack in the same cycle as req is legal.
REQ-019 d_mode SHALL be 1 exactly in HALTED and RESUME.
REQ-020 In HALTED, dbg_resume_req SHALL transition to RESUME; RESUME SHALL last one cycle with resumed=1, then go to IDLE.
REQ-021 On RESUME, skip_once SHALL set; while skip_once=1, break_any SHALL be ignored for cause selection.
REQ-022 skip_once SHALL clear on the first x_retire in IDLE.
REQ-023 If dbg_step=1 at RESUME, step_pending SHALL set; the first x_retire then SHALL set step_armed and clear step_pending.
REQ-024 step_armed SHALL clear on any entry to M_REQ or D_REQ.
REQ-025 dbg_halt_req while not IDLE SHALL be held off (no latch) and re-evaluated at the next IDLE fire.
REQ-026 Inputs other than acks and dbg_resume_req SHALL be ignored outside IDLE, and x_kill SHALL be 0 outside IDLE.

Reset
REQ-027 On rst: state=IDLE, all outputs 0 (d_pc=0, d_cause=0), and skip_once, step_pending, step_armed cleared.
REQ-028 rst mid-handshake SHALL drop the req the next cycle without waiting for ack.

Structure
REQ-029 State encodings and dcsr cause codes (EBREAK=1, TRIGGER=2, HALTREQ=3, STEP=4) SHALL live in the shared hazard3 package/header beside the CSR addresses.
REQ-030 The block SHALL have no sub-module; the cause priority encoder SHALL be an internal function.

Verification
REQ-031 break_any=1, break_d_mode=1, x_pc=0x1000, X fires -> x_kill=1 same cycle; d_entry_req next cycle; d_cause=2, d_pc=0x1000; ack -> d_mode=1.
REQ-032 break_any=1, break_d_mode=0 -> m_trap_req held 5 cycles without ack, then ack -> IDLE; d_mode stays 0.
REQ-033 break_any, x_ebreak&&ebreakm and dbg_halt_req together -> d_cause=2.
REQ-034 HALTED, resume with trigger still matching at 0x1000 -> resumed pulse 1 cycle; first instruction not killed and retires; next match at 0x1004 -> kill, cause 2.
REQ-035 Resume with dbg_step=1 -> one instruction retires, next fire at 0x2004 -> d_entry_req, d_cause=4, d_pc=0x2004.
REQ-036 rst asserted in D_REQ -> next cycle d_entry_req=0, d_mode=0, state IDLE.
